rr_mux_sel_arbiter: RTL
=======================

// Module: rr_mux_sel_arbiter
// PURPOSE
//   Round-robin arbiter that drives the 2-bit select of the 4:1 bit mux stage
//   directly downstream. Four requesters compete for the mux. One is granted
//   at a time, and its index is presented on sel for the whole grant. sel only
//   changes after a one-cycle idle bubble, so the mux output never switches
//   mid-grant.
// PARAMETERS
//   HOLD_MAX  16  max consecutive grant cycles before forced release; 0 = unlimited
// PORTS
//   clk        in   1  single clock, all state on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   4  request per channel, level-sensitive, bit i = channel i
//   done       in   1  current grantee finished; sampled only in GRANT
//   sel        out  2  mux select = index of granted channel (registered)
//   gnt        out  4  one-hot grant (registered); 4'b0000 when idle
//   gnt_valid  out  1  high whenever gnt != 0
// BEHAVIOUR
//   Reset (async, immediate, no clock needed):
//     state=IDLE, gnt=0, gnt_valid=0, sel=0, ptr=0, hold_cnt=0.
//   State machine: IDLE, GRANT.
//     IDLE:
//       - done is ignored.
//       - If req!=0 at the edge: pick the first set bit scanning ptr, ptr+1, ..
//         mod 4. Load sel/gnt with that channel, set gnt_valid=1, hold_cnt=0,
//         go to GRANT.
//       - Latency: req seen at edge n -> gnt visible in cycle n+1.
//       - If req==0: stay in IDLE. sel holds its last value; gnt=0.
//     GRANT:
//       - Release at the edge when any of these is true:
//         (a) done=1;
//         (b) req[sel]=0;
//         (c) HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1.
//       - Otherwise hold_cnt increments, saturating, width clog2(HOLD_MAX+1), min 1.
//       - On release: gnt=0, gnt_valid=0, ptr=(sel+1) mod 4, go to IDLE.
//         sel is unchanged.
//     The cycle in which the release condition is sampled is the last grant
//     cycle. A grant therefore lasts at most HOLD_MAX cycles.
//   Bubble: every release spends exactly one cycle in IDLE, even when other
//     requests are pending. Back-to-back grants therefore have a 1-cycle gap.
//   Priority after release: the released channel becomes lowest priority. If it
//     re-requests during the bubble, it is granted only if no other req is set.
//   Simultaneous release causes (done + req drop + timeout in the same cycle)
//     count as one release. ptr advances once.
//   req changes on non-granted channels during GRANT have no effect on the
//     current grant.
//   Invariants:
//     - gnt is always one-hot or zero.
//     - gnt_valid == |gnt.
//     - When gnt_valid=1, gnt == (4'b0001 << sel).
//   Reset mid-grant: all outputs clear immediately on rst_n fall. After rst_n
//     rises, arbitration restarts with ch0 highest priority.
//   No combinational path from inputs to outputs.
// TESTING
//   1 rst_n=0 mid-run, no clk edge -> gnt=0000, gnt_valid=0, sel=00 immediately
//   2 req=0100 from cycle 0 -> cycle 1: gnt=0100, sel=2, gnt_valid=1;
//     done=1 in cycle 3 -> cycle 4: gnt=0000, sel stays 2
//   3 req=1111 held, done=1 on every grant cycle -> sel 0,1,2,3,0 with one
//     gnt_valid=0 cycle between each grant
//   4 HOLD_MAX=8, req=0011 held, done=0 -> ch0 granted exactly 8 cycles,
//     1 idle cycle, then ch1 granted 8 cycles, then ch0
//   5 ch1 granted, req=0011 -> req=0001 (ch1 drops) -> next cycle gnt=0,
//     then ch0 granted; ptr=2
//   6 ch3 granted, release with req=1000 still set -> bubble, ch3 re-granted
//     (only requester); then with req=1001 -> ch0 wins over ch3

Source files
------------

// File: rtl/rr_mux_sel_arbiter_if.sv
// Arbiter <-> requester/mux bundle for the 4-channel round-robin mux-select arbiter.
// gnt_valid qualifies sel/gnt; there is no ready: a grant ends when done, req[sel] drop or the hold limit releases it.
interface rr_mux_sel_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;

    modport master (
        input  req,
        input  done,
        output sel,
        output gnt,
        output gnt_valid
    );

    modport slave (
        output req,
        output done,
        input  sel,
        input  gnt,
        input  gnt_valid
    );
endinterface

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux.
// sel is stable for a whole grant and every release is followed by one idle cycle.
module rr_mux_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_mux_sel_arbiter_if.master  bus,
    output logic                  state_dbg,
    output logic [1:0]            ptr_dbg
);

    localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             HOLD_ON  = (HOLD_MAX != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       scan_idx;
    logic             release_now;

    // Scan from ptr upward with wrap; the descending loop lets the lowest offset win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (bus.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        release_now = bus.done
                    | ~bus.req[sel_q]
                    | (HOLD_ON & (hold_cnt_q == CNT_LAST));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 2'd0;
            gnt_q      <= 4'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = 4'd0;
                if (pick_found) begin
                    state_d    = S_GRANT;
                    sel_d      = pick_idx;
                    gnt_d      = 4'b0001 << pick_idx;
                    hold_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    // sel is left alone so the mux output does not move during the bubble.
                    state_d = S_IDLE;
                    gnt_d   = 4'd0;
                    ptr_d   = sel_q + 2'd1;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        bus.sel       = sel_q;
        bus.gnt       = gnt_q;
        bus.gnt_valid = |gnt_q;
        state_dbg     = state_q;
        ptr_dbg       = ptr_q;
    end

endmodule
